// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8-bit UART transmitter (8N1). Each bit lasts BPS_DIV clocks.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity
// bit is sent between the last data bit and the stop bit (8E1).
// Handshake: the upstream controller holds TX_En_Sig high until it sees
// TX_Done_Sig. TX_Done_Sig is a one-cycle pulse at the end of each frame.
module uart_tx_engine #(
  parameter int unsigned BPS_DIV = 434
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       TX_En_Sig,
  input  logic [7:0] TX_Data,
  output logic       TX_Done_Sig,
  output logic       TX_Busy,
  output logic       TX_Pin_Out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DONE
  } state_t;

  localparam logic [15:0] LP_DIV_M1 = 16'(BPS_DIV - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_pin;
  logic        r_busy;
  logic        r_done;
`ifdef UART_TX_PARITY_EN
  logic        r_parity;
`endif

  logic        w_bit_end;

  // The current bit ends when the counter reaches its last cycle.
  assign w_bit_end = (r_cnt == LP_DIV_M1);

  // Frame sequencer: the state, the counters, the shift register and all the outputs are registered here.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_pin     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_done    <= 1'b0;
          if (TX_En_Sig) begin
            r_shift  <= TX_Data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^TX_Data;
`endif
            r_pin    <= 1'b0;
            r_busy   <= 1'b1;
            r_state  <= S_START;
          end else begin
            r_pin  <= 1'b1;
            r_busy <= 1'b0;
          end
        end

        // The shift register moves right as each bit goes out. The next line
        // value is always r_shift[0], so no mux on the bit index is needed.
        S_START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_pin   <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_pin   <= r_parity;
              r_state <= S_PARITY;
`else
              r_pin   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_pin     <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_pin   <= 1'b1;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_pin   <= 1'b1;
          r_state <= S_IDLE;
        end

        default: begin
          r_cnt     <= '0;
          r_bit_idx <= '0;
          r_pin     <= 1'b1;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign TX_Pin_Out  = r_pin;
  assign TX_Busy     = r_busy;
  assign TX_Done_Sig = r_done;

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 The block SHALL have parameter BPS_DIV, default 434, meaning clock cycles per bit (50 MHz / 115200); legal range 2..65535.
REQ-002 The block SHALL have port CLK  input  1  system clock; all logic on the rising edge.
REQ-003 The block SHALL have port RSTn  input  1  reset; synchronous and active-low.
REQ-004 The block SHALL have port TX_En_Sig  input  1  transmit request; the upstream controller holds it high until it sees TX_Done_Sig.
REQ-005 The block SHALL have port TX_Data  input  8  byte to send; sampled only at frame start.
REQ-006 The block SHALL have port TX_Done_Sig  output  1  one-cycle pulse marking the end of a frame.
REQ-007 The block SHALL have port TX_Busy  output  1  high while a frame is in progress.
REQ-008 The block SHALL have port TX_Pin_Out  output  1  serial line; registered; idle high.

Function
REQ-009 The state machine SHALL have the states IDLE, START, DATA, [PARITY], STOP and DONE.
REQ-010 In IDLE, a rising edge with TX_En_Sig=1 SHALL latch TX_Data into an internal shift register, drive TX_Pin_Out=0, set TX_Busy=1 and enter START; that edge is edge 0.
REQ-011 With TX_En_Sig=0 in IDLE, all outputs SHALL hold their idle values: TX_Pin_Out=1, TX_Busy=0, TX_Done_Sig=0.
REQ-012 Each bit SHALL last exactly BPS_DIV cycles, timed by a 16-bit counter that counts 0..BPS_DIV-1 and then wraps to 0 at each bit boundary.
REQ-013 The frame SHALL be: start bit 0, then 8 data bits LSB first, then [parity], then stop bit 1.
REQ-014 A bit-index counter SHALL advance through the data bits 0..7, and the block SHALL leave DATA after bit 7 completes.
REQ-015 After the stop bit's final cycle, the block SHALL enter DONE for exactly one cycle with TX_Done_Sig=1, TX_Pin_Out=1 and TX_Busy=1.
REQ-016 Without parity, TX_Done_Sig SHALL be high during cycle 10*BPS_DIV+1 counted from edge 0.
REQ-017 DONE SHALL go to IDLE unconditionally, and TX_Busy SHALL fall at the same edge.
REQ-018 The block SHALL ignore TX_En_Sig in every state other than IDLE.
REQ-019 The block SHALL ignore changes on TX_Data after edge 0.
REQ-020 If TX_En_Sig is held high continuously, frames SHALL repeat with exactly 2 extra high cycles (DONE + IDLE) between one stop bit and the next start bit.
REQ-021 A controller that drops TX_En_Sig on the edge where it samples TX_Done_Sig=1 SHALL get exactly one frame per request.
REQ-022 TX_Done_Sig SHALL never be high for more than one consecutive cycle.

Reset
REQ-023 When RSTn=0 at a rising edge, the block SHALL set state=IDLE, clear both counters and the shift register, and drive TX_Pin_Out=1, TX_Busy=0, TX_Done_Sig=0.
REQ-024 A reset mid-frame SHALL abort the frame with no TX_Done_Sig pulse, and the line SHALL be high from the next edge.
REQ-025 The first frame after reset release SHALL be complete and correct.

Configuration
REQ-026 Macro UART_TX_PARITY_EN: when defined, the block SHALL insert a PARITY state between DATA and STOP that sends even parity (XOR of the 8 latched bits) for BPS_DIV cycles.
REQ-027 With UART_TX_PARITY_EN defined, the frame SHALL be 11 bits and TX_Done_Sig SHALL be high during cycle 11*BPS_DIV+1.
REQ-028 Without UART_TX_PARITY_EN, the block SHALL contain no parity logic and the frame SHALL be 10 bits.

Verification (BPS_DIV=4)
REQ-029 Scenario 1: TX_Data=0x55 with a one-request handshake -> line shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles; TX_Done_Sig high only in cycle 41; TX_Busy high in cycles 1..41.
REQ-030 Scenario 2: TX_Data=0xA3, then TX_Data changed to 0xFF during data bit 3 -> serial data still shows 0xA3 (1,1,0,0,0,1,0,1).
REQ-031 Scenario 3: RSTn=0 for one edge during data bit 4 of 0x3C -> line high and TX_Busy=0 from the next edge, no TX_Done_Sig; then a 0x0F request -> correct frame, TX_Done_Sig at cycle 41.
REQ-032 Scenario 4: TX_En_Sig held high with TX_Data=0x00 -> two frames, second start bit begins 2 cycles after the first stop bit ends; two TX_Done_Sig pulses 42 cycles apart.
REQ-033 Scenario 5: UART_TX_PARITY_EN defined, TX_Data=0x07 -> parity bit 1 in cycles 37..40, stop bit in cycles 41..44, TX_Done_Sig in cycle 45; TX_Data=0x03 -> parity bit 0.
REQ-034 Scenario 6: request driven by an upstream FIFO-read controller, 3 queued bytes 0x11, 0x22, 0x33 -> three frames in order, three TX_Done_Sig pulses, no duplicated frame.
